// File: rtl/hazard_scoreboard_pkg.sv
// Shared core constants: register index width, countdown width, bank encoding and unit latencies.
// Decode and the hazard scoreboard both read these, so their latency assumptions cannot drift apart.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int LAT_W     = 4;

  typedef enum logic {
    BANK_INT = 1'b0,
    BANK_FP  = 1'b1
  } bank_e;

  // Cycles until the result reaches a forwarding point in EX.
  localparam int LAT_LOAD    = 1;
  localparam int FPU_LAT_ADD = 3;
  localparam int FPU_LAT_MUL = 4;
  localparam int FPU_LAT_DIV = 12;

  // Integer x0 is hardwired to zero: it is never written and never a hazard.
  function automatic logic is_int_zero(input logic fp, input logic [REG_IDX_W-1:0] r);
    return (fp == BANK_INT) && (r == '0);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage issue and source-operand bundle plus the scoreboard's stall/busy replies.
// master = ID decode side, slave = hazard scoreboard.
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = hazard_scoreboard_pkg::LAT_W
);

  logic                 issue_v_i;
  logic                 issue_wb_i;
  logic [REG_IDX_W-1:0] issue_rd_i;
  logic                 issue_fp_i;
  logic [LAT_W-1:0]     issue_lat_i;
  logic                 freeze_i;

  logic [REG_IDX_W-1:0] rs1_i;
  logic                 rs1_fp_i;
  logic                 rs1_use_i;
  logic [REG_IDX_W-1:0] rs2_i;
  logic                 rs2_fp_i;
  logic                 rs2_use_i;
  logic [REG_IDX_W-1:0] rs3_i;
  logic                 rs3_fp_i;
  logic                 rs3_use_i;

  logic                 stall_o;
  logic                 busy_o;

  modport master (
    output issue_v_i, issue_wb_i, issue_rd_i, issue_fp_i, issue_lat_i, freeze_i,
    output rs1_i, rs1_fp_i, rs1_use_i,
    output rs2_i, rs2_fp_i, rs2_use_i,
    output rs3_i, rs3_fp_i, rs3_use_i,
    input  stall_o, busy_o
  );

  modport slave (
    input  issue_v_i, issue_wb_i, issue_rd_i, issue_fp_i, issue_lat_i, freeze_i,
    input  rs1_i, rs1_fp_i, rs1_use_i,
    input  rs2_i, rs2_fp_i, rs2_use_i,
    input  rs3_i, rs3_fp_i, rs3_use_i,
    output stall_o, busy_o
  );

endinterface

// File: rtl/hazard_scoreboard_sb_entry.sv
// One in-flight write slot: pending flag plus a countdown to the cycle the result becomes forwardable.
// Latency: set visible next cycle. Backpressure: none; freeze holds the countdown.
module sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = hazard_scoreboard_pkg::LAT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             set_en,
  input  logic [LAT_W-1:0] set_lat,
  input  logic             freeze,
  output logic             pend
);

  logic [LAT_W-1:0] cnt;

  // A new set outranks an expiry landing on the same edge.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (set_en) begin
      pend <= 1'b1;
      cnt  <= set_lat;
    end else if (pend && !freeze) begin
      cnt <= cnt - 1'b1;
      if (cnt == LAT_W'(1)) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks register writes not yet forwardable and stalls ID on RAW or WAW hazards against them.
// Latency: stall/busy are combinational from state and ID inputs. Backpressure: stall_o holds PC/IF-ID/ID-EX.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = hazard_scoreboard_pkg::LAT_W
) (
  input logic               clk_i,
  input logic               reset_i,
  hazard_scoreboard_if.slave sb
);

  localparam int ENTRIES = 2 * NUM_REGS;
  localparam int IDX_W   = $clog2(ENTRIES);

  function automatic logic [IDX_W-1:0] entry_of(input logic fp, input logic [REG_IDX_W-1:0] r);
    return fp ? (IDX_W'(NUM_REGS) + IDX_W'(r)) : IDX_W'(r);
  endfunction

  logic [ENTRIES-1:0]   pend;
  logic [IDX_W-1:0]     issue_entry;
  logic                 issue_cand;
  logic                 raw_hit;
  logic                 waw_hit;
  logic                 stall;
  logic                 track;

  logic [2:0]           src_use;
  logic [2:0]           src_fp;
  logic [REG_IDX_W-1:0] src_idx [3];

  assign src_use    = {sb.rs3_use_i, sb.rs2_use_i, sb.rs1_use_i};
  assign src_fp     = {sb.rs3_fp_i,  sb.rs2_fp_i,  sb.rs1_fp_i};
  assign src_idx[0] = sb.rs1_i;
  assign src_idx[1] = sb.rs2_i;
  assign src_idx[2] = sb.rs3_i;

  always_comb begin
    raw_hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (src_use[k] && !is_int_zero(src_fp[k], src_idx[k]) &&
          pend[entry_of(src_fp[k], src_idx[k])]) begin
        raw_hit = 1'b1;
      end
    end
  end

  // issue_wb_i is active-low in the pipeline encoding.
  assign issue_entry = entry_of(sb.issue_fp_i, sb.issue_rd_i);
  assign issue_cand  = sb.issue_v_i && !sb.issue_wb_i && (sb.issue_lat_i != '0) &&
                       !is_int_zero(sb.issue_fp_i, sb.issue_rd_i);
  assign waw_hit     = issue_cand && pend[issue_entry];

  // Outputs are forced low while reset is held so no stall leaks across reset.
  assign stall      = reset_i && (raw_hit || waw_hit);
  assign track      = issue_cand && !stall;
  assign sb.stall_o = stall;
  assign sb.busy_o  = reset_i && (|pend);

  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    sb_entry #(
      .LAT_W (LAT_W)
    ) u_entry (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .set_en  (track && (issue_entry == IDX_W'(e))),
      .set_lat (sb.issue_lat_i),
      .freeze  (sb.freeze_i),
      .pend    (pend[e])
    );
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Random and directed stimulus against a remaining-cycles reference model; a monitor pops expected stall/busy.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct packed {
    logic            rst;
    logic            v;
    logic            wb;
    logic [4:0]      rd;
    logic            fp;
    logic [3:0]      lat;
    logic            frz;
    logic [2:0][4:0] rs;
    logic [2:0]      rsfp;
    logic [2:0]      rsu;
  } stim_t;

  typedef struct packed {
    logic stall;
    logic busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.LAT_W(4)) ifc ();

  hazard_scoreboard #(.NUM_REGS(32), .LAT_W(4)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .sb      (ifc)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   rem [64];
  exp_t exp_q [$];
  logic act_stall;
  logic act_busy;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int idx(input logic fp, input logic [4:0] r);
    return (fp ? 32 : 0) + int'(r);
  endfunction

  function automatic stim_t nop();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    s.wb  = 1'b1;
    return s;
  endfunction

  function automatic stim_t issue(input logic fp, input logic [4:0] rd, input int lat);
    stim_t s;
    s     = nop();
    s.v   = 1'b1;
    s.wb  = 1'b0;
    s.fp  = fp;
    s.rd  = rd;
    s.lat = 4'(lat);
    return s;
  endfunction

  function automatic stim_t reader(input int n, input logic fp, input logic [4:0] r);
    stim_t s;
    s          = nop();
    s.rsu[n]   = 1'b1;
    s.rsfp[n]  = fp;
    s.rs[n]    = r;
    return s;
  endfunction

  // Drive one cycle, predict outputs from the model, then advance the model.
  task automatic cycle(input stim_t s);
    logic raw, cand, es, eb;
    int   ie;
    @(posedge clk);
    #1;
    rst_n           = s.rst;
    ifc.issue_v_i   = s.v;
    ifc.issue_wb_i  = s.wb;
    ifc.issue_rd_i  = s.rd;
    ifc.issue_fp_i  = s.fp;
    ifc.issue_lat_i = s.lat;
    ifc.freeze_i    = s.frz;
    ifc.rs1_i = s.rs[0]; ifc.rs1_fp_i = s.rsfp[0]; ifc.rs1_use_i = s.rsu[0];
    ifc.rs2_i = s.rs[1]; ifc.rs2_fp_i = s.rsfp[1]; ifc.rs2_use_i = s.rsu[1];
    ifc.rs3_i = s.rs[2]; ifc.rs3_fp_i = s.rsfp[2]; ifc.rs3_use_i = s.rsu[2];

    raw = 1'b0;
    for (int k = 0; k < 3; k++)
      if (s.rsu[k] && !(s.rsfp[k] == 1'b0 && s.rs[k] == 5'd0) && rem[idx(s.rsfp[k], s.rs[k])] > 0)
        raw = 1'b1;
    ie   = idx(s.fp, s.rd);
    cand = s.v && !s.wb && s.lat != 0 && !(s.fp == 1'b0 && s.rd == 5'd0);
    es   = s.rst && (raw || (cand && rem[ie] > 0));
    eb   = 1'b0;
    for (int e = 0; e < 64; e++) if (rem[e] > 0) eb = 1'b1;
    eb   = eb && s.rst;
    exp_q.push_back('{stall: es, busy: eb});

    if (!s.rst) begin
      for (int e = 0; e < 64; e++) rem[e] = 0;
    end else begin
      if (!s.frz)
        for (int e = 0; e < 64; e++) if (rem[e] > 0) rem[e] = rem[e] - 1;
      if (cand && !es) rem[ie] = int'(s.lat);
    end
    #3;
    act_stall = ifc.stall_o;
    act_busy  = ifc.busy_o;
  endtask

  // Repeat s until stall drops; freeze is held for the first frz_n cycles.
  task automatic count_stall(input stim_t s, input int frz_n, output int n);
    stim_t t;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      t     = s;
      t.frz = (i < frz_n);
      cycle(t);
      if (!act_stall) return;
      n++;
    end
    check("stall_timeout", n, -1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_stall", int'(ifc.stall_o), int'(e.stall));
        check("model_busy", int'(ifc.busy_o), int'(e.busy));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    int    n;
    for (int e = 0; e < 64; e++) rem[e] = 0;
    cycle(nop());

    // Reset held with random issue traffic.
    for (int i = 0; i < 6; i++) begin
      s     = issue(1'($urandom), 5'($urandom_range(0, 31)), $urandom_range(1, 15));
      s.rst = 1'b0;
      cycle(s);
    end
    cycle(nop());
    check("reset_busy", int'(act_busy), 0);
    check("reset_stall", int'(act_stall), 0);

    // Load-use, then an unrelated reader.
    cycle(issue(BANK_INT, 5'd5, LAT_LOAD));
    count_stall(reader(0, BANK_INT, 5'd5), 0, n);
    check("load_use_stalls", n, 1);
    cycle(issue(BANK_INT, 5'd5, LAT_LOAD));
    cycle(reader(0, BANK_INT, 5'd6));
    check("x6_no_stall", int'(act_stall), 0);
    repeat (2) cycle(nop());

    // FPU op to f3 read through rs3, with and without freeze.
    cycle(issue(BANK_FP, 5'd3, FPU_LAT_MUL));
    count_stall(reader(2, BANK_FP, 5'd3), 0, n);
    check("fpu_lat4_stalls", n, 4);
    cycle(issue(BANK_FP, 5'd3, FPU_LAT_MUL));
    count_stall(reader(2, BANK_FP, 5'd3), 2, n);
    check("fpu_freeze_stalls", n, 6);

    // Bank isolation and x0/f0 handling.
    cycle(issue(BANK_INT, 5'd7, 3));
    cycle(reader(0, BANK_FP, 5'd7));
    check("f7_no_stall", int'(act_stall), 0);
    repeat (4) cycle(nop());
    cycle(issue(BANK_INT, 5'd0, 3));
    cycle(nop());
    check("x0_not_busy", int'(act_busy), 0);
    cycle(issue(BANK_FP, 5'd0, 2));
    cycle(reader(1, BANK_FP, 5'd0));
    check("f0_busy", int'(act_busy), 1);
    check("f0_stall", int'(act_stall), 1);
    repeat (3) cycle(nop());

    // WAW: f2 pending for 3, younger lat=1 write waits then is tracked.
    cycle(issue(BANK_FP, 5'd2, 3));
    count_stall(issue(BANK_FP, 5'd2, 1), 0, n);
    check("waw_stalls", n, 3);
    cycle(nop());
    check("waw_accepted_busy", int'(act_busy), 1);
    cycle(nop());
    check("waw_drained", int'(act_busy), 0);

    // Reset mid-operation.
    cycle(issue(BANK_INT, 5'd9, 5));
    cycle(issue(BANK_FP, 5'd1, 2));
    s     = nop();
    s.rst = 1'b0;
    cycle(s);
    cycle(reader(0, BANK_INT, 5'd9));
    check("post_reset_stall", int'(act_stall), 0);
    check("post_reset_busy", int'(act_busy), 0);

    // Random traffic on a narrow register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      s      = nop();
      s.rst  = ($urandom_range(0, 99) != 0);
      s.v    = 1'($urandom);
      s.wb   = ($urandom_range(0, 3) == 0);
      s.rd   = 5'($urandom_range(0, 7));
      s.fp   = 1'($urandom);
      s.lat  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 6));
      s.frz  = ($urandom_range(0, 7) == 0);
      for (int k = 0; k < 3; k++) begin
        s.rs[k]   = 5'($urandom_range(0, 7));
        s.rsfp[k] = 1'($urandom);
        s.rsu[k]  = 1'($urandom);
      end
      cycle(s);
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
